// File: rtl/seq_stream_checker.sv
// Sink-side checker for the 8-bit counting stream: verifies 0..LIMIT-1 in order, accumulates count/sum.
// Optional idle watchdog in RECV is compiled in with SEQ_STREAM_CHECKER_TIMEOUT_EN.
module seq_stream_checker #(
    parameter int unsigned LIMIT   = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [7:0]  err_data,
    output logic [7:0]  count,
    output logic [15:0] sum
);
    // state  | meaning
    // S_IDLE | waiting for the first beat, which must be 0
    // S_RECV | receiving; next beat must equal expected
    // S_DONE | value LIMIT-1 received, holds until clear/reset
    // S_ERR  | first violation recorded, holds until clear/reset
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_ERR} state_t;

    localparam logic [7:0] LAST_VAL = 8'(LIMIT - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START    = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    if (LIMIT < 2 || LIMIT > 255) begin : g_bad_limit
        $error("seq_stream_checker: LIMIT out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("seq_stream_checker: TIMEOUT out of range");
    end

    state_t      state, state_nx;
    logic [7:0]  expected, expected_nx;
    logic [7:0]  count_nx;
    logic [15:0] sum_nx;
    logic        done_nx, error_nx;
    logic [1:0]  err_code_nx;
    logic [7:0]  err_data_nx;
    logic        beat;

`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
    logic [7:0] idle_cnt, idle_cnt_nx;
`endif

    assign in_ready = (state == S_IDLE || state == S_RECV) && !clear;
    assign beat     = in_valid && in_ready;

    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        count_nx    = count;
        sum_nx      = sum;
        done_nx     = done;
        error_nx    = error;
        err_code_nx = err_code;
        err_data_nx = err_data;
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
        idle_cnt_nx = idle_cnt;
`endif
        if (clear) begin
            state_nx    = S_IDLE;
            expected_nx = 8'd0;
            count_nx    = 8'd0;
            sum_nx      = 16'd0;
            done_nx     = 1'b0;
            error_nx    = 1'b0;
            err_code_nx = ERR_NONE;
            err_data_nx = 8'd0;
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
            idle_cnt_nx = 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (beat) begin
                        if (in_data == 8'd0) begin
                            state_nx    = S_RECV;
                            count_nx    = 8'd1;
                            sum_nx      = 16'd0;
                            expected_nx = 8'd1;
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
                            idle_cnt_nx = 8'd0;
`endif
                        end else begin
                            state_nx    = S_ERR;
                            error_nx    = 1'b1;
                            err_code_nx = ERR_START;
                            err_data_nx = in_data;
                        end
                    end
                end
                S_RECV: begin
                    if (beat) begin
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
                        idle_cnt_nx = 8'd0;
`endif
                        if (in_data == expected) begin
                            count_nx    = count + 8'd1;
                            sum_nx      = sum + {8'd0, in_data};
                            expected_nx = expected + 8'd1;
                            if (in_data == LAST_VAL) begin
                                state_nx = S_DONE;
                                done_nx  = 1'b1;
                            end
                        end else begin
                            // count/sum keep the last good values for debug
                            state_nx    = S_ERR;
                            error_nx    = 1'b1;
                            err_code_nx = ERR_MISMATCH;
                            err_data_nx = in_data;
                        end
                    end
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
                    else if (idle_cnt == IDLE_LAST) begin
                        state_nx    = S_ERR;
                        error_nx    = 1'b1;
                        err_code_nx = ERR_TIMEOUT;
                        err_data_nx = 8'd0;
                    end else begin
                        idle_cnt_nx = idle_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: ;
                S_ERR:  ;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            expected <= 8'd0;
            count    <= 8'd0;
            sum      <= 16'd0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            err_data <= 8'd0;
        end else begin
            state    <= state_nx;
            expected <= expected_nx;
            count    <= count_nx;
            sum      <= sum_nx;
            done     <= done_nx;
            error    <= error_nx;
            err_code <= err_code_nx;
            err_data <= err_data_nx;
        end
    end

`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) idle_cnt <= 8'd0;
        else       idle_cnt <= idle_cnt_nx;
    end
`endif

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed + random bench for seq_stream_checker against a queue-based reference model.
module tb_seq_stream_checker;
    localparam int LIMIT   = 10;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, done, error;
    logic [1:0]  err_code;
    logic [7:0]  err_data, count;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;

    // reference model: accepted values kept in a queue; count/sum derived from it
    int  acc_q[$];
    bit  m_started, m_done, m_err;
    int  m_code, m_edata, m_idle;

    seq_stream_checker #(.LIMIT(LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .done(done), .error(error), .err_code(err_code),
        .err_data(err_data), .count(count), .sum(sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_sum();
        int s = 0;
        foreach (acc_q[i]) s += acc_q[i];
        return s;
    endfunction

    task automatic model_reset();
        acc_q.delete();
        m_started = 0; m_done = 0; m_err = 0;
        m_code = 0; m_edata = 0; m_idle = 0;
    endtask

    function automatic bit model_ready(input bit clr);
        return !clr && !m_done && !m_err;
    endfunction

    task automatic model_step(input bit v, input int d, input bit clr);
        if (clr) begin
            model_reset();
        end else if (v && model_ready(0)) begin
            m_idle = 0;
            if (!m_started) begin
                if (d == 0) begin m_started = 1; acc_q.push_back(0); end
                else begin m_err = 1; m_code = 1; m_edata = d; end
            end else if (d == acc_q.size()) begin
                acc_q.push_back(d);
                if (d == LIMIT - 1) m_done = 1;
            end else begin
                m_err = 1; m_code = 2; m_edata = d;
            end
        end else if (m_started && !m_done && !m_err) begin
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT) begin m_err = 1; m_code = 3; m_edata = 0; end
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".done"},     32'(done),     32'(m_done));
        chk({tag, ".error"},    32'(error),    32'(m_err));
        chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
        chk({tag, ".err_data"}, 32'(err_data), 32'(m_edata));
        chk({tag, ".count"},    32'(count),    32'(acc_q.size()));
        chk({tag, ".sum"},      32'(sum),      32'(q_sum()));
    endtask

    // one clock: drive just after the previous edge, check ready, clock, check registered outputs
    task automatic cycle(input bit v, input int d, input bit clr, input string tag);
        in_valid = v; in_data = 8'(d); clear = clr;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready(clr)));
        model_step(v, d, clr);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_seq(input int from, input int to, input string tag);
        for (int i = from; i <= to; i++) cycle(1, i, 0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check_outputs(tag);
        #2 reset = 1'b0;
        in_valid = 0; clear = 0;
        @(posedge clk);
        #1;
        check_outputs({tag, ".post"});
    endtask

    initial begin
        reset = 1'b1; clear = 0; in_valid = 0; in_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        check_outputs("rst");

        // full sequence back to back
        send_seq(0, 9, "seq");
        chk("seq.done_c", 32'(done), 32'd1);
        chk("seq.sum_c", 32'(sum), 32'd45);
        cycle(1, 3, 0, "seq_hold");
        chk("seq.ready_c", 32'(in_ready), 32'd0);
        chk("seq.count_c", 32'(count), 32'd10);

        // mismatch
        cycle(0, 0, 1, "clr1");
        send_seq(0, 2, "mm");
        cycle(1, 5, 0, "mm_bad");
        chk("mm.code_c", 32'(err_code), 32'd2);
        chk("mm.data_c", 32'(err_data), 32'd5);
        chk("mm.sum_c", 32'(sum), 32'd3);
        cycle(1, 3, 0, "mm_ign");
        cycle(1, 9, 0, "mm_ign2");

        // bad start
        cycle(0, 0, 1, "clr2");
        cycle(1, 3, 0, "bs");
        chk("bs.code_c", 32'(err_code), 32'd1);
        chk("bs.data_c", 32'(err_data), 32'd3);

        // clear wins over a simultaneous beat
        cycle(0, 0, 1, "clr3");
        send_seq(0, 4, "pre");
        cycle(1, 5, 1, "clr_beat");
        chk("clr_beat.count_c", 32'(count), 32'd0);
        send_seq(0, 9, "fresh");
        chk("fresh.sum_c", 32'(sum), 32'd45);

        // idle gap of TIMEOUT cycles
        cycle(0, 0, 1, "clr4");
        send_seq(0, 1, "to_pre");
        for (int i = 0; i < TIMEOUT; i++) cycle(0, 0, 0, "to_gap");
`ifdef SEQ_STREAM_CHECKER_TIMEOUT_EN
        chk("to.code_c", 32'(err_code), 32'd3);
        chk("to.count_c", 32'(count), 32'd2);
`else
        chk("to.ready_c", 32'(in_ready), 32'd1);
        send_seq(2, 9, "to_cont");
        chk("to.done_c", 32'(done), 32'd1);
`endif

        // async reset mid-sequence
        cycle(0, 0, 1, "clr5");
        send_seq(0, 6, "pre_rst");
        pulse_reset("arst");
        send_seq(0, 9, "post_rst");
        chk("post_rst.count_c", 32'(count), 32'd10);

        // random: mostly correct streams with gaps, glitches and occasional clears
        for (int n = 0; n < 400; n++) begin
            int d;
            bit v, clr;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0) || ((m_done || m_err) && $urandom_range(0, 3) == 0);
            d   = acc_q.size();
            if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 255);
            if (!m_started && $urandom_range(0, 7) != 0) d = 0;
            if ($urandom_range(0, 60) == 0) begin
                for (int k = 0; k < TIMEOUT + 2; k++) cycle(0, 0, 0, "rnd_gap");
            end
            cycle(v, d, clr, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end
endmodule
